// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: port 0 (ALU) has priority,
// port 1 (multi-cycle unit) is buffered in a 2-entry FIFO and protected from starvation.
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_WAIT      = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_data,
    output logic                     req1_ready,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]    WD3,
    output logic [1:0]               fifo_count
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [ADDRESS_WIDTH-1:0] fifo_addr [2];
    logic [DATA_WIDTH-1:0]    fifo_data [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;
    logic [3:0]               wait_cnt;

    logic                     fifo_empty;
    logic                     force_head;
    logic                     issue0;
    logic                     pop;
    logic                     push;
    logic [ADDRESS_WIDTH-1:0] issue_addr;
    logic [DATA_WIDTH-1:0]    issue_data;

    // Handshake: a transfer happens on a port when valid && ready at the rising clk edge.
    // Both readies come only from registered state (count, wait_cnt), never from the valids.
    assign fifo_empty = (count == 2'd0);
    assign force_head = !fifo_empty && (wait_cnt == WAIT_LIMIT);
    assign req0_ready = !force_head;
    assign req1_ready = (count < 2'd2);
    assign fifo_count = count;

    assign push   = req1_valid && req1_ready;
    assign issue0 = req0_valid && !force_head;
    assign pop    = !issue0 && !fifo_empty;

    assign issue_addr = issue0 ? req0_addr : fifo_addr[rd_ptr];
    assign issue_data = issue0 ? req0_data : fifo_data[rd_ptr];

    // FIFO storage needs no reset; validity is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= req1_addr;
            fifo_data[wr_ptr] <= req1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            wait_cnt <= 4'd0;
            WE3      <= 1'b0;
            AD3      <= '0;
            WD3      <= '0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop)  rd_ptr <= !rd_ptr;

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (pop || fifo_empty)
                wait_cnt <= 4'd0;
            else if (issue0)
                wait_cnt <= wait_cnt + 4'd1;

            // Writes to x0 still consume their slot but never assert the write enable.
            if (issue0 || pop) begin
                WE3 <= (issue_addr != '0);
                AD3 <= issue_addr;
                WD3 <= issue_data;
            end else begin
                WE3 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single writes, starvation guard,
// FIFO-full back-pressure, x0 filtering and asynchronous reset mid-operation.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          WE3;
    logic [AW-1:0] AD3;
    logic [DW-1:0] WD3;
    logic [1:0]    fifo_count;

    int n_checks;
    int n_pass;

    logic [AW-1:0] exp_q[$];

    regfile_wb_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .MAX_WAIT     (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .WE3       (WE3),
        .AD3       (AD3),
        .WD3       (WD3),
        .fifo_count(fifo_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drive0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_valid = 1'b1;
        req0_addr  = a;
        req0_data  = d;
    endtask

    task automatic drive1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_valid = 1'b1;
        req1_addr  = a;
        req1_data  = d;
    endtask

    initial begin
        logic [AW-1:0] r0a;
        int            idx;
        logic          acc0;
        logic          acc1;
        logic [AW-1:0] ea;
        logic [12:0]   r0_tbl;
        logic [12:0]   r1_tbl;
        logic [4:0]    s0_tbl;

        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b1;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_data  = '0;

        // reset values
        #2 rst_n = 1'b0;
        #2;
        check("rst_we3", 32'(WE3), 32'd0);
        check("rst_ad3", 32'(AD3), 32'd0);
        check("rst_wd3", WD3, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd1);
        check("rst_ready1", 32'(req1_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // single port 0 write
        drive0(5'd5, 32'hDEADBEEF);
        step();
        drive_idle();
        check("p0_we3", 32'(WE3), 32'd1);
        check("p0_ad3", 32'(AD3), 32'd5);
        check("p0_wd3", WD3, 32'hDEADBEEF);
        step();
        check("p0_we3_drop", 32'(WE3), 32'd0);

        // port 1 buffering
        drive1(5'd7, 32'h11);
        step();
        drive_idle();
        check("p1_count1", 32'(fifo_count), 32'd1);
        check("p1_no_bypass", 32'(WE3), 32'd0);
        step();
        check("p1_we3", 32'(WE3), 32'd1);
        check("p1_ad3", 32'(AD3), 32'd7);
        check("p1_wd3", WD3, 32'h11);
        check("p1_count0", 32'(fifo_count), 32'd0);

        // starvation guard: one FIFO entry vs continuous port 0 traffic
        drive1(5'd9, 32'h900);
        step();
        drive_idle();
        exp_q  = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd4};
        s0_tbl = 5'b10111;
        r0a    = 5'd1;
        for (int k = 0; k < 5; k++) begin
            drive0(r0a, 32'h100 + 32'(r0a));
            #1;
            check($sformatf("sg_ready0_%0d", k), 32'(req0_ready), 32'(s0_tbl[k]));
            acc0 = req0_ready;
            step();
            if (acc0) r0a = r0a + 5'd1;
            ea = exp_q.pop_front();
            check($sformatf("sg_we3_%0d", k), 32'(WE3), 32'd1);
            check($sformatf("sg_ad3_%0d", k), 32'(AD3), 32'(ea));
        end
        drive_idle();
        step();

        // FIFO full: req0 saturating, three req1 entries 10, 11, 12
        exp_q  = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd10, 5'd24, 5'd25,
                   5'd26, 5'd11, 5'd27, 5'd28, 5'd29, 5'd12};
        r0_tbl = 13'b0111011101111;
        r1_tbl = 13'b1111000100011;
        r0a    = 5'd20;
        idx    = 0;
        for (int k = 0; k < 13; k++) begin
            drive0(r0a, 32'h100 + 32'(r0a));
            if (idx < 3) drive1(5'(10 + idx), 32'h200 + 32'(10 + idx));
            else req1_valid = 1'b0;
            #1;
            check($sformatf("ff_ready0_%0d", k), 32'(req0_ready), 32'(r0_tbl[k]));
            check($sformatf("ff_ready1_%0d", k), 32'(req1_ready), 32'(r1_tbl[k]));
            acc0 = req0_ready;
            acc1 = req1_valid && req1_ready;
            step();
            if (acc0) r0a = r0a + 5'd1;
            if (acc1) idx++;
            ea = exp_q.pop_front();
            check($sformatf("ff_we3_%0d", k), 32'(WE3), 32'd1);
            check($sformatf("ff_ad3_%0d", k), 32'(AD3), 32'(ea));
            check($sformatf("ff_wd3_%0d", k), WD3,
                  (ea >= 5'd10 && ea <= 5'd12) ? 32'h200 + 32'(ea) : 32'h100 + 32'(ea));
        end
        drive_idle();
        check("ff_drained", 32'(fifo_count), 32'd0);
        step();
        check("ff_idle_we3", 32'(WE3), 32'd0);

        // x0 filter
        drive0(5'd0, 32'hFFFFFFFF);
        #1;
        check("x0_ready0", 32'(req0_ready), 32'd1);
        step();
        drive_idle();
        check("x0_we3", 32'(WE3), 32'd0);
        check("x0_ad3", 32'(AD3), 32'd0);
        check("x0_wd3", WD3, 32'hFFFFFFFF);

        // async reset with a full FIFO
        drive0(5'd29, 32'h129);
        drive1(5'd13, 32'h213);
        step();
        drive0(5'd30, 32'h130);
        drive1(5'd14, 32'h214);
        step();
        drive_idle();
        check("ar_full", 32'(fifo_count), 32'd2);
        check("ar_we3_before", 32'(WE3), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_we3", 32'(WE3), 32'd0);
        check("ar_count", 32'(fifo_count), 32'd0);
        check("ar_ready1", 32'(req1_ready), 32'd1);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("ar_no_stale_%0d", k), 32'(WE3), 32'd0);
        end
        drive0(5'd6, 32'h66);
        step();
        drive_idle();
        check("ar_post_we3", 32'(WE3), 32'd1);
        check("ar_post_ad3", 32'(AD3), 32'd6);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
